// File: rtl/reg_file_reader.sv
// Sequential read-out engine for reg_file: walks an address window through the
// asynchronous read port and streams each word over a valid/ready handshake.
module reg_file_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic        [ADDR_WIDTH-1:0] first_addr,
    input  logic        [ADDR_WIDTH:0]   num_words,
    output logic        [ADDR_WIDTH-1:0] r_addr,
    input  logic signed [DATA_WIDTH-1:0] r_data,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         busy,
    output logic                         done
);

    typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

    localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH + 1)'(1) << ADDR_WIDTH;

    state_t                       state_q;
    logic        [ADDR_WIDTH-1:0] addr_q;
    logic        [ADDR_WIDTH:0]   remaining_q;
    logic        [ADDR_WIDTH:0]   remaining_d;
    logic signed [DATA_WIDTH-1:0] outData_q;
    logic                         outValid_q;
    logic                         busy_q;
    logic                         done_q;

    // Oversized counts saturate so no entry is emitted twice in one transfer.
    assign remaining_d = (num_words > DEPTH) ? DEPTH : num_words;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            outData_q   <= '0;
            outValid_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (num_words != '0) begin
                            addr_q      <= first_addr;
                            remaining_q <= remaining_d;
                            busy_q      <= 1'b1;
                            state_q     <= LOAD;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                // r_data is captured here, so a write on this same edge is not seen.
                LOAD: begin
                    outData_q  <= r_data;
                    outValid_q <= 1'b1;
                    state_q    <= HOLD;
                end
                HOLD: begin
                    if (outValid_q && out_ready) begin
                        outValid_q <= 1'b0;
                        if (remaining_q == (ADDR_WIDTH + 1)'(1)) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            addr_q      <= addr_q + 1'b1;
                            remaining_q <= remaining_q - 1'b1;
                            state_q     <= LOAD;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign r_addr    = addr_q;
    assign out_data  = outData_q;
    assign out_valid = outValid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_reg_file_reader.sv
// Scoreboard bench for reg_file_reader with a behavioural reg_file beside it:
// expected words are queued at start time and popped on every handshake.
module tb_reg_file_reader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] first_addr = '0;
    logic [2:0] num_words = '0;
    logic [1:0] r_addr;
    logic [7:0] r_data;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       busy;
    logic       done;

    logic [7:0] mem [4] = '{8'h0A, 8'hFD, 8'h7F, 8'h80};
    logic       we = 1'b0;
    logic [1:0] wAddr = '0;
    logic [7:0] wData = '0;

    int total = 0;
    int bad = 0;
    int cycleCount = 0;
    int donePulses = 0;
    int doneMark = 0;
    int doneEdge = 0;
    int startEdge = 0;
    bit randomReady = 1'b0;

    logic [7:0] expData [$];
    logic [1:0] expAddr [$];
    int         hsEdges [$];

    reg_file_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .first_addr (first_addr),
        .num_words  (num_words),
        .r_addr     (r_addr),
        .r_data     (r_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    assign r_data = mem[r_addr];

    always @(posedge clk) begin
        cycleCount <= cycleCount + 1;
        if (we) mem[wAddr] <= wData;
    end

    always @(posedge clk) begin
        #1;
        if (randomReady) out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at cycle %0d", name, actual, expected, cycleCount);
        end
    endtask

    // Monitor: every handshake pops one expected word/address from the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                hsEdges.push_back(cycleCount + 1);
                if (expData.size() == 0) begin
                    checkOutput("unexpected word", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    checkOutput("out_data", 32'(out_data), 32'(expData.pop_front()));
                    checkOutput("r_addr at handshake", 32'(r_addr), 32'(expAddr.pop_front()));
                end
            end
            if (done) begin
                donePulses++;
                doneEdge = cycleCount;
                checkOutput("busy low with done", 32'(busy), 32'd0);
            end
        end
    end

    // Reference: the window is min(n,4) consecutive addresses modulo 4, read at start time.
    task automatic applyStimulus(input int first, input int n);
        int cnt;
        cnt = (n > 4) ? 4 : n;
        @(posedge clk); #1;
        for (int i = 0; i < cnt; i++) begin
            expAddr.push_back(2'((first + i) % 4));
            expData.push_back(mem[(first + i) % 4]);
        end
        doneMark = donePulses;
        hsEdges.delete();
        start = 1'b1;
        first_addr = 2'(first);
        num_words = 3'(n);
        @(posedge clk); #1;
        start = 1'b0;
        startEdge = cycleCount;
        if (n != 0) begin
            checkOutput("busy after start", 32'(busy), 32'd1);
            checkOutput("r_addr after start", 32'(r_addr), 32'(first));
            checkOutput("done after start", 32'(done), 32'd0);
        end else begin
            checkOutput("zero-length done", 32'(done), 32'd1);
            checkOutput("zero-length busy", 32'(busy), 32'd0);
        end
    endtask

    task automatic waitDone(input int maxCycles);
        int c = 0;
        while (donePulses == doneMark && c < maxCycles) begin
            @(posedge clk); #1;
            c++;
        end
        checkOutput("done seen in time", 32'(donePulses > doneMark), 32'd1);
        repeat (2) begin
            @(posedge clk); #1;
        end
        checkOutput("single done pulse", 32'(donePulses - doneMark), 32'd1);
        checkOutput("scoreboard drained", 32'(expData.size()), 32'd0);
        checkOutput("busy idle", 32'(busy), 32'd0);
    endtask

    initial begin
        #12;
        checkOutput("reset out_data", 32'(out_data), 32'd0);
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset r_addr", 32'(r_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Full dump with exact handshake timing.
        out_ready = 1'b1;
        applyStimulus(0, 4);
        waitDone(40);
        checkOutput("full dump handshakes", 32'(hsEdges.size()), 32'd4);
        for (int i = 0; i < hsEdges.size(); i++)
            checkOutput("handshake spacing", 32'(hsEdges[i] - startEdge), 32'(2 * (i + 1)));
        checkOutput("done timing", 32'(doneEdge - startEdge), 32'd8);

        // Wrap-around window.
        applyStimulus(3, 2);
        waitDone(40);
        checkOutput("wrap handshakes", 32'(hsEdges.size()), 32'd2);

        // Backpressure on the first word.
        out_ready = 1'b0;
        applyStimulus(0, 4);
        @(posedge clk); #1;
        repeat (5) begin
            checkOutput("stall out_valid", 32'(out_valid), 32'd1);
            checkOutput("stall out_data", 32'(out_data), 32'h0A);
            checkOutput("stall r_addr", 32'(r_addr), 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        waitDone(60);

        // Zero-length and saturated counts.
        applyStimulus(1, 0);
        repeat (3) begin
            checkOutput("zero-length no valid", 32'(out_valid), 32'd0);
            @(posedge clk); #1;
        end
        waitDone(10);
        applyStimulus(2, 7);
        waitDone(60);
        checkOutput("saturated word count", 32'(hsEdges.size()), 32'd4);

        // Write on the LOAD edge of addr 1 must not be seen; a later transfer sees it.
        applyStimulus(1, 1);
        we = 1'b1; wAddr = 2'd1; wData = 8'h55;
        @(posedge clk); #1;
        we = 1'b0;
        waitDone(20);
        applyStimulus(1, 1);
        waitDone(20);
        checkOutput("written value", 32'(mem[1]), 32'h55);

        // Start while busy is ignored.
        applyStimulus(0, 4);
        start = 1'b1; first_addr = 2'd2; num_words = 3'd1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b0;
        waitDone(60);
        checkOutput("ignored start handshakes", 32'(hsEdges.size()), 32'd4);

        // Asynchronous reset mid-transfer.
        out_ready = 1'b0;
        applyStimulus(0, 4);
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort out_valid", 32'(out_valid), 32'd0);
        checkOutput("abort busy", 32'(busy), 32'd0);
        checkOutput("abort done", 32'(done), 32'd0);
        expData.delete();
        expAddr.delete();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        applyStimulus(1, 1);
        waitDone(20);

        // Randomized transfers with random backpressure.
        randomReady = 1'b1;
        for (int t = 0; t < 20; t++) begin
            applyStimulus(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)));
            waitDone(200);
        end
        randomReady = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
